// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single dmem port between the CPU LSU (m0) and a debug/loader master (m1)
// Ports:
//   clk, reset_n          clock and synchronous active-low reset
//   mN_req/address/write_enable/write_mode/write_data/read_mode   requester N inputs (N=0,1)
//   mN_gnt                request accepted this cycle (combinational)
//   mN_rvalid/mN_rdata    load response for the requester owning the inflight access
//   mem_*                 memory-side request (address, enables, modes, write data)
//   mem_read_data/mem_wait memory response data and busy (second half of unaligned access)
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration between m0 and m1;
//   left undefined, m0 has fixed priority over m1.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_write_enable,
  input  logic [2:0]        m0_write_mode,
  input  logic [DATA_W-1:0] m0_write_data,
  input  logic [2:0]        m0_read_mode,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_write_enable,
  input  logic [2:0]        m1_write_mode,
  input  logic [DATA_W-1:0] m1_write_data,
  input  logic [2:0]        m1_read_mode,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_enable,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [2:0]        mem_write_mode,
  output logic [2:0]        mem_read_mode,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_wait
);
  typedef enum logic [1:0] {IDLE, RESP, STALL} state_t;
  state_t state;
  logic live, hold, acc, win, due, s_we;
  logic h_en, h_we, f_own, f_load;
  logic [ADDR_W-1:0] h_addr, s_addr;
  logic [2:0] h_wm, h_rm, s_wm, s_rm;
  logic [DATA_W-1:0] h_wd, s_wd;
  // A new request can only be taken when the memory is free and reset is released
  assign live = reset_n && !mem_wait;
  assign hold = reset_n && mem_wait;
`ifdef ARB_ROUND_ROBIN_EN
  logic prio;
  // prio=1 favours m1; it always points away from the most recent winner
  assign win = m1_req && (!m0_req || prio);
`else
  assign win = !m0_req;
`endif
  assign acc = live && (m0_req || m1_req);
  assign m0_gnt = acc && !win;
  assign m1_gnt = acc && win;
  assign s_addr = win ? m1_address : m0_address;
  assign s_we = win ? m1_write_enable : m0_write_enable;
  assign s_wm = win ? m1_write_mode : m0_write_mode;
  assign s_rm = win ? m1_read_mode : m0_read_mode;
  assign s_wd = win ? m1_write_data : m0_write_data;
  // While the memory is busy it must keep seeing the request it accepted
  always_comb begin
    mem_enable = hold ? h_en : acc;
    mem_write_enable = hold ? h_en && h_we : acc && s_we;
    mem_read_enable = hold ? h_en && !h_we : acc && !s_we;
    mem_address = hold ? h_addr : acc ? s_addr : '0;
    mem_write_mode = hold ? h_wm : acc ? s_wm : '0;
    mem_read_mode = hold ? h_rm : acc ? s_rm : '0;
    mem_write_data = hold ? h_wd : acc ? s_wd : '0;
  end
  // The inflight access answers in the first cycle the memory is not busy
  assign due = live && state != IDLE && f_load;
  assign m0_rvalid = due && !f_own;
  assign m1_rvalid = due && f_own;
  assign m0_rdata = m0_rvalid ? mem_read_data : '0;
  assign m1_rdata = m1_rvalid ? mem_read_data : '0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      h_en <= 1'b0;
      h_we <= 1'b0;
      h_addr <= '0;
      h_wm <= '0;
      h_rm <= '0;
      h_wd <= '0;
      f_own <= 1'b0;
      f_load <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      prio <= 1'b0;
`endif
    end else begin
      state <= (mem_wait && state != IDLE) ? STALL : acc ? RESP : IDLE;
      if (!mem_wait) h_en <= acc;
      if (acc) begin
        h_we <= s_we;
        h_addr <= s_addr;
        h_wm <= s_wm;
        h_rm <= s_rm;
        h_wd <= s_wd;
        f_own <= win;
        f_load <= !s_we;
`ifdef ARB_ROUND_ROBIN_EN
        prio <= !win;
`endif
      end
    end
  end
endmodule
